// File: rtl/xb_fifo_reader.sv
// xb_fifo_reader: drains the DDR->wavelet FIFO into a framed valid/ready sample stream.
// A small output buffer absorbs the FIFO read latency so back-pressure never over-reads the FIFO.
module xb_fifo_reader #(
  parameter int DATA_W     = 16,
  parameter int FRAME_LEN  = 256,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk_150_90,
  input  logic              reset_syn_n,
  input  logic              xb_en,
  output logic              fifo_xb_rreq,
  input  logic [DATA_W-1:0] fifo_xb_r_data,
  input  logic [2:0]        fifo_xb_use,
  input  logic              fifo_xb_full,
  output logic [DATA_W-1:0] xb_data,
  output logic              xb_valid,
  input  logic              xb_ready,
  output logic              xb_sof,
  output logic              xb_eof,
  output logic [15:0]       frame_cnt,
  output logic              busy
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int AW    = $clog2(OBUF_DEPTH);
  localparam int OCC_W = AW + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_rreq;
  logic               r_inflight;
  logic [IDX_W-1:0]   r_rdIdx;
  logic [IDX_W-1:0]   r_tagIdx;
  logic [DATA_W-1:0]  r_memData [OBUF_DEPTH];
  logic               r_memSof  [OBUF_DEPTH];
  logic               r_memEof  [OBUF_DEPTH];
  logic [AW-1:0]      r_wrPtr;
  logic [AW-1:0]      r_rdPtr;
  logic [OCC_W-1:0]   r_occ;
  logic [15:0]        r_frameCnt;

  logic [3:0]         w_avail;
  logic [OCC_W:0]     w_pending;
  logic               w_canRead;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  // r_rreq is a read the FIFO takes at the coming edge and is not yet visible in usedw;
  // r_inflight is data on the FIFO bus now that lands in the buffer at the coming edge.
  assign w_avail   = fifo_xb_full ? 4'd8 : {1'b0, fifo_xb_use};
  assign w_pending = {1'b0, r_occ} + (OCC_W+1)'(r_rreq) + (OCC_W+1)'(r_inflight);
  assign w_issue   = w_canRead && (w_avail > {3'b000, r_rreq})
                     && (w_pending < (OCC_W+1)'(OBUF_DEPTH));
  assign w_push    = r_inflight;
  assign w_pop     = xb_valid && xb_ready;

  always_comb begin
    w_canRead = 1'b0;
    w_next    = r_state;
    case (r_state)
      S_IDLE: begin
        if (xb_en) w_next = S_RUN;
      end
      S_RUN: begin
        // With xb_en low a new frame must not be started, only the current one finished.
        w_canRead = xb_en || (r_rdIdx != '0);
        if (!xb_en) w_next = (r_rdIdx == '0) ? S_FLUSH : S_DRAIN;
      end
      S_DRAIN: begin
        w_canRead = (r_rdIdx != '0);
        if (xb_en) w_next = S_RUN;
        else if (r_rdIdx == '0) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (xb_en) w_next = S_RUN;
        else if (!r_rreq && !r_inflight && (r_occ == '0)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_150_90 or negedge reset_syn_n) begin
    if (!reset_syn_n) begin
      r_state    <= S_IDLE;
      r_rreq     <= 1'b0;
      r_inflight <= 1'b0;
      r_rdIdx    <= '0;
      r_tagIdx   <= '0;
    end else begin
      r_state    <= w_next;
      r_rreq     <= w_issue;
      r_inflight <= r_rreq;
      if (w_issue) r_rdIdx <= (r_rdIdx == LAST_IDX) ? '0 : r_rdIdx + 1'b1;
      if (w_push) r_tagIdx <= (r_tagIdx == LAST_IDX) ? '0 : r_tagIdx + 1'b1;
    end
  end

  always_ff @(posedge clk_150_90 or negedge reset_syn_n) begin
    if (!reset_syn_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) begin
        r_memData[i] <= '0;
        r_memSof[i]  <= 1'b0;
        r_memEof[i]  <= 1'b0;
      end
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_occ      <= '0;
      r_frameCnt <= '0;
    end else begin
      if (w_push) begin
        r_memData[r_wrPtr] <= fifo_xb_r_data;
        r_memSof[r_wrPtr]  <= (r_tagIdx == '0);
        r_memEof[r_wrPtr]  <= (r_tagIdx == LAST_IDX);
        r_wrPtr            <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
        if (r_memEof[r_rdPtr]) r_frameCnt <= r_frameCnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign fifo_xb_rreq = r_rreq;
  assign xb_valid     = (r_occ != '0);
  assign xb_data      = r_memData[r_rdPtr];
  assign xb_sof       = xb_valid && r_memSof[r_rdPtr];
  assign xb_eof       = xb_valid && r_memEof[r_rdPtr];
  assign frame_cnt    = r_frameCnt;
  assign busy         = (r_state != S_IDLE) || xb_valid;

  // The read-issue rule reserves space for every outstanding read, so a push into a full buffer is a bug.
  assert property (@(posedge clk_150_90) disable iff (!reset_syn_n)
    !(w_push && !w_pop && (r_occ == OCC_W'(OBUF_DEPTH))));

endmodule

// File: tb/tb_xb_fifo_reader.sv
// Testbench for xb_fifo_reader: behavioural FIFO, random traffic, and an in-order scoreboard
// that tags every expected sample by its position in the frame.
module tb_xb_fifo_reader;

  localparam int DATA_W     = 16;
  localparam int FRAME_LEN  = 8;
  localparam int OBUF_DEPTH = 4;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        s;
    logic        e;
  } outRec_t;

  logic              clk_150_90 = 1'b0;
  logic              reset_syn_n = 1'b0;
  logic              xb_en = 1'b0;
  logic              fifo_xb_rreq;
  logic [DATA_W-1:0] fifo_xb_r_data = '0;
  logic [2:0]        fifo_xb_use = '0;
  logic              fifo_xb_full = 1'b0;
  logic [DATA_W-1:0] xb_data;
  logic              xb_valid;
  logic              xb_ready = 1'b0;
  logic              xb_sof;
  logic              xb_eof;
  logic [15:0]       frame_cnt;
  logic              busy;

  logic [15:0] fifoQ[$];
  logic [15:0] srcQ[$];
  logic [15:0] expQ[$];
  outRec_t     outQ[$];
  bit          srcEn = 1'b0;

  int errors = 0, checks = 0, cyc = 0;
  int readsTaken = 0, hsTaken = 0, maxOut = 0, underflows = 0, stallErr = 0;
  int expIdx = 0, expFrames = 0;

  bit          prevStall = 1'b0;
  logic [15:0] prevData;
  logic        prevSof, prevEof;

  xb_fifo_reader #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .clk_150_90     (clk_150_90),
    .reset_syn_n    (reset_syn_n),
    .xb_en          (xb_en),
    .fifo_xb_rreq   (fifo_xb_rreq),
    .fifo_xb_r_data (fifo_xb_r_data),
    .fifo_xb_use    (fifo_xb_use),
    .fifo_xb_full   (fifo_xb_full),
    .xb_data        (xb_data),
    .xb_valid       (xb_valid),
    .xb_ready       (xb_ready),
    .xb_sof         (xb_sof),
    .xb_eof         (xb_eof),
    .frame_cnt      (frame_cnt),
    .busy           (busy)
  );

  always #5 clk_150_90 = ~clk_150_90;

  // 8-word FIFO with 1-cycle read latency; upstream writes at most one word per cycle from srcQ.
  always @(posedge clk_150_90) begin : fifoModel
    bit rr;
    rr = fifo_xb_rreq;
    cyc++;
    #1;
    if (rr) begin
      readsTaken++;
      if (fifoQ.size() == 0) underflows++;
      else fifo_xb_r_data = fifoQ.pop_front();
    end
    if (srcEn && srcQ.size() > 0 && fifoQ.size() < 8) fifoQ.push_back(srcQ.pop_front());
    fifo_xb_full = (fifoQ.size() == 8);
    fifo_xb_use  = 3'(fifoQ.size() % 8);
  end

  // Records every handshake and watches buffered-read depth and stall stability.
  always @(negedge clk_150_90) begin : outMon
    outRec_t rec;
    if (!reset_syn_n) prevStall = 1'b0;
    else begin
      if (readsTaken - hsTaken > maxOut) maxOut = readsTaken - hsTaken;
      if (prevStall && (!xb_valid || xb_data !== prevData || xb_sof !== prevSof || xb_eof !== prevEof))
        stallErr++;
      if (xb_valid && xb_ready) begin
        rec.cyc = cyc; rec.d = xb_data; rec.s = xb_sof; rec.e = xb_eof;
        outQ.push_back(rec);
        hsTaken++;
      end
      prevStall = xb_valid && !xb_ready;
      prevData = xb_data; prevSof = xb_sof; prevEof = xb_eof;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Next expected sample: data in write order, tags from its position within the frame.
  function automatic void modelNext(output logic [15:0] d, output logic s, output logic e);
    d = expQ.pop_front();
    s = (expIdx % FRAME_LEN) == 0;
    e = (expIdx % FRAME_LEN) == FRAME_LEN - 1;
    if (e) expFrames = (expFrames + 1) % 65536;
    expIdx++;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_150_90);
    #2;
  endtask

  task automatic pushWord(input logic [15:0] w);
    srcQ.push_back(w);
    expQ.push_back(w);
  endtask

  task automatic waitOut(input int n, input int budget, output bit ok);
    int k = 0;
    while (outQ.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (outQ.size() >= n);
  endtask

  task automatic test_reset();
    reset_syn_n = 1'b0;
    for (int i = 0; i < 5; i++) srcQ.push_back(16'(16'hA000 + i));
    srcEn = 1'b1;
    tick(8);
    checks++; if (fifo_xb_rreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_rreq: got %b expected 0", fifo_xb_rreq); end
    checks++; if (xb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", xb_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({xb_sof, xb_eof, xb_data} !== 18'd0) begin errors++; $display("[TB] FAIL reset_tags_data: got sof=%b eof=%b data=%h expected 0/0/0", xb_sof, xb_eof, xb_data); end
    reset_syn_n = 1'b1;
    tick(6);
    checks++; if (readsTaken !== 0) begin errors++; $display("[TB] FAIL idle_no_read: got %0d reads expected 0", readsTaken); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    srcEn = 1'b0;
    fifoQ.delete();
    srcQ.delete();
    readsTaken = 0;
    tick(2);
  endtask

  task automatic test_streaming();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    bit ok;
    int prevCyc = -1;
    for (int i = 0; i < 16; i++) pushWord(16'(i));
    srcEn = 1'b1;
    tick(10);
    xb_ready = 1'b1;
    xb_en = 1'b1;
    waitOut(16, 80, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL stream_timeout: got %0d samples expected 16", outQ.size()); end
    tick(2);
    while (outQ.size() > 0) begin
      rec = outQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL stream_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL stream_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
        if (prevCyc >= 0) begin
          checks++;
          if (rec.cyc !== prevCyc + 1) begin errors++; $display("[TB] FAIL stream_gap: got cycle %0d expected %0d", rec.cyc, prevCyc + 1); end
        end
      end
      prevCyc = rec.cyc;
    end
    checks++; if (frame_cnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL stream_frame_cnt: got %0d expected %0d", frame_cnt, expFrames); end
  endtask

  task automatic test_back_pressure();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    int k = 0;
    maxOut = 0;
    stallErr = 0;
    for (int i = 0; i < 24; i++) pushWord(16'($urandom));
    while (outQ.size() < 24 && k < 400) begin
      xb_ready = (k % 3 == 0);
      tick(1);
      k++;
    end
    xb_ready = 1'b1;
    tick(2);
    checks++; if (outQ.size() !== 24) begin errors++; $display("[TB] FAIL bp_count: got %0d samples expected 24", outQ.size()); end
    while (outQ.size() > 0) begin
      rec = outQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL bp_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL bp_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
      end
    end
    checks++; if (maxOut > OBUF_DEPTH) begin errors++; $display("[TB] FAIL bp_outstanding: got %0d expected <= %0d", maxOut, OBUF_DEPTH); end
    checks++; if (stallErr !== 0) begin errors++; $display("[TB] FAIL bp_stall_stable: got %0d changes expected 0", stallErr); end
    checks++; if (frame_cnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL bp_frame_cnt: got %0d expected %0d", frame_cnt, expFrames); end
  endtask

  task automatic test_full_wrap();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    bit ok, seen;
    int base;
    xb_en = 1'b0;
    tick(6);
    base = readsTaken;
    for (int i = 0; i < 8; i++) pushWord(16'($urandom));
    tick(12);
    checks++; if (readsTaken !== base) begin errors++; $display("[TB] FAIL wrap_idle_reads: got %0d expected 0", readsTaken - base); end
    xb_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick(1);
      seen = (fifo_xb_rreq === 1'b1);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL wrap_start: got rreq=%b expected 1 within 3 cycles", fifo_xb_rreq); end
    waitOut(8, 60, ok);
    tick(12);
    checks++; if (readsTaken - base !== 8) begin errors++; $display("[TB] FAIL wrap_reads: got %0d expected 8", readsTaken - base); end
    checks++; if (underflows !== 0) begin errors++; $display("[TB] FAIL wrap_underflow: got %0d expected 0", underflows); end
    checks++; if (outQ.size() !== 8) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected 8", outQ.size()); end
    while (outQ.size() > 0) begin
      rec = outQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL wrap_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL wrap_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
      end
    end
  endtask

  task automatic test_stop_midframe();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    bit ok;
    int base, k;
    base = readsTaken;
    for (int i = 0; i < 4; i++) pushWord(16'(16'h5000 + i));
    k = 0;
    while (readsTaken - base < 4 && k < 40) begin tick(1); k++; end
    checks++; if (readsTaken - base !== 4) begin errors++; $display("[TB] FAIL stop_first_half: got %0d reads expected 4", readsTaken - base); end
    xb_en = 1'b0;
    for (int i = 4; i < 11; i++) pushWord(16'(16'h5000 + i));
    waitOut(8, 80, ok);
    tick(15);
    checks++; if (readsTaken - base !== 8) begin errors++; $display("[TB] FAIL stop_reads: got %0d expected 8", readsTaken - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy: got %b expected 0", busy); end
    checks++; if (outQ.size() !== 8) begin errors++; $display("[TB] FAIL stop_count: got %0d expected 8", outQ.size()); end
    while (outQ.size() > 0) begin
      rec = outQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL stop_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL stop_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
      end
    end
    checks++; if (frame_cnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL stop_frame_cnt: got %0d expected %0d", frame_cnt, expFrames); end
  endtask

  task automatic test_underrun();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    bit ok;
    int validSeen = 0, gapCyc = 0;
    xb_en = 1'b1;
    waitOut(3, 40, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL underrun_first: got %0d samples expected 3", outQ.size()); end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (xb_valid === 1'b1) validSeen++;
    end
    checks++; if (validSeen !== 0) begin errors++; $display("[TB] FAIL underrun_gap: got valid in %0d cycles expected 0", validSeen); end
    for (int i = 3; i < 8; i++) pushWord(16'($urandom));
    waitOut(8, 60, ok);
    tick(2);
    for (int i = 0; outQ.size() > 0; i++) begin
      rec = outQ.pop_front();
      if (i == 3) gapCyc = rec.cyc - gapCyc;
      else gapCyc = rec.cyc;
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL underrun_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL underrun_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
      end
      if (i == 3) begin
        checks++;
        if (gapCyc <= 20) begin errors++; $display("[TB] FAIL underrun_resume: got gap %0d cycles expected > 20", gapCyc); end
      end
    end
    checks++; if (frame_cnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL underrun_frame_cnt: got %0d expected %0d", frame_cnt, expFrames); end
  endtask

  task automatic test_random();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    int k = 0;
    maxOut = 0;
    stallErr = 0;
    srcEn = 1'b0;
    for (int i = 0; i < 40; i++) pushWord(16'($urandom));
    while (outQ.size() < 40 && k < 800) begin
      srcEn = ($urandom_range(0, 1) == 1);
      xb_ready = ($urandom_range(0, 2) != 0);
      tick(1);
      k++;
    end
    srcEn = 1'b1;
    xb_ready = 1'b1;
    tick(2);
    checks++; if (outQ.size() !== 40) begin errors++; $display("[TB] FAIL rand_count: got %0d expected 40", outQ.size()); end
    while (outQ.size() > 0) begin
      rec = outQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL rand_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL rand_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
      end
    end
    checks++; if (maxOut > OBUF_DEPTH) begin errors++; $display("[TB] FAIL rand_outstanding: got %0d expected <= %0d", maxOut, OBUF_DEPTH); end
    checks++; if (stallErr !== 0) begin errors++; $display("[TB] FAIL rand_stall_stable: got %0d changes expected 0", stallErr); end
    checks++; if (underflows !== 0) begin errors++; $display("[TB] FAIL rand_underflow: got %0d expected 0", underflows); end
    checks++; if (frame_cnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL rand_frame_cnt: got %0d expected %0d", frame_cnt, expFrames); end
  endtask

  task automatic test_reset_midframe();
    outRec_t rec;
    logic [15:0] ed; logic es, ee;
    bit ok;
    for (int i = 0; i < 5; i++) pushWord(16'($urandom));
    waitOut(2, 40, ok);
    reset_syn_n = 1'b0;
    #1;
    checks++; if ({fifo_xb_rreq, xb_valid, busy} !== 3'b000) begin errors++; $display("[TB] FAIL midreset_outputs: got rreq=%b valid=%b busy=%b expected 000", fifo_xb_rreq, xb_valid, busy); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("[TB] FAIL midreset_frame_cnt: got %0d expected 0", frame_cnt); end
    fifoQ.delete(); srcQ.delete(); expQ.delete(); outQ.delete();
    expIdx = 0; expFrames = 0; readsTaken = 0; hsTaken = 0;
    tick(3);
    reset_syn_n = 1'b1;
    for (int i = 0; i < 8; i++) pushWord(16'($urandom));
    waitOut(8, 80, ok);
    tick(3);
    checks++; if (outQ.size() !== 8) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 8", outQ.size()); end
    while (outQ.size() > 0) begin
      rec = outQ.pop_front();
      checks++;
      if (expQ.size() == 0) begin errors++; $display("[TB] FAIL midreset_extra: got data %h expected none", rec.d); end
      else begin
        modelNext(ed, es, ee);
        if ({rec.d, rec.s, rec.e} !== {ed, es, ee}) begin
          errors++; $display("[TB] FAIL midreset_sample: got %h sof=%b eof=%b expected %h sof=%b eof=%b", rec.d, rec.s, rec.e, ed, es, ee);
        end
      end
    end
    checks++; if (frame_cnt !== 16'(expFrames)) begin errors++; $display("[TB] FAIL midreset_frame_cnt_after: got %0d expected %0d", frame_cnt, expFrames); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_full_wrap();
    test_stop_midframe();
    test_underrun();
    test_random();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
